vh_pow_iter: RTL

VH_POW_ITER -- requirements
Module: vh_pow_iter

---
 rtl/vh_pow_pkg.sv | 21 ++
 rtl/vh_pow_step.sv | 22 ++
 rtl/vh_pow_iter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/vh_pow_pkg.sv
// Shared types for the iterative integer power unit (vh_pow_iter).
//   state_e : control FSM states
//   sc_e    : special-case classification of an accepted operand pair
package vh_pow_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    NONE,       // ordinary case, iterate
    ZERO_EXP,   // b == 0 -> 1
    UNDEF,      // 0 ** negative -> x
    ONE,        // 1 ** negative -> 1
    MINUS_ONE,  // -1 ** negative -> +/-1 by parity
    ZERO        // any other base ** negative -> 0
  } sc_e;

endpackage

// File: rtl/vh_pow_step.sv
// One truncating square-and-multiply step, purely combinational.
//   acc_i       : running product
//   base_i      : current base power (a ** 2^k)
//   bit_i       : exponent bit k
//   acc_next_o  : acc_i * base_i when bit_i is set, else acc_i (truncated)
//   base_next_o : base_i squared (truncated)
module vh_pow_step #(
  parameter int Y_WIDTH = 8
) (
  input  logic [Y_WIDTH-1:0] acc_i,
  input  logic [Y_WIDTH-1:0] base_i,
  input  logic               bit_i,
  output logic [Y_WIDTH-1:0] acc_next_o,
  output logic [Y_WIDTH-1:0] base_next_o
);

  always_comb begin
    acc_next_o  = bit_i ? acc_i * base_i : acc_i;
    base_next_o = base_i * base_i;
  end

endmodule

// File: rtl/vh_pow_iter.sv
// Iterative integer power: y = a ** b modulo 2^Y_WIDTH, with IEEE 1364-2005
// semantics for negative exponents. LSB-first square-and-multiply, one
// exponent bit per cycle; special cases resolve in a single cycle.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b                : base and exponent, captured on accept
//   out_valid/out_ready : result handshake (valid only in DONE)
//   y, y_undef          : result and "result is x" flag (0 ** negative)
// Build option: define VH_POW_EARLY_EXIT_EN to leave RUN as soon as the
// remaining exponent bits are all zero; results are identical either way.
module vh_pow_iter
  import vh_pow_pkg::*;
#(
  parameter int A_WIDTH  = 8,
  parameter int B_WIDTH  = 8,
  parameter int Y_WIDTH  = 8,
  parameter int A_SIGNED = 0,
  parameter int B_SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Y_WIDTH-1:0] y,
  output logic               y_undef
);

  localparam int CW = $clog2(B_WIDTH + 1);

  state_e             state_q, state_d;
  logic [Y_WIDTH-1:0] acc_q, acc_d;
  logic [Y_WIDTH-1:0] base_q, base_d;
  logic [B_WIDTH-1:0] exp_q, exp_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               undef_q, undef_d;

  logic [64:0]        a_wide;
  logic [Y_WIDTH-1:0] a_ext;
  logic               b_neg;
  sc_e                sc;
  logic [Y_WIDTH-1:0] special_y;
  logic [Y_WIDTH-1:0] acc_step, base_step;
  logic               last_step;

  // The base is classified on its full extended value so that a base wider
  // than Y_WIDTH is not mistaken for 0/1/-1 after truncation.
  always_comb begin
    if (A_SIGNED != 0) a_wide = {{(65-A_WIDTH){a[A_WIDTH-1]}}, a};
    else               a_wide = {{(65-A_WIDTH){1'b0}}, a};
  end

  assign a_ext = a_wide[Y_WIDTH-1:0];
  assign b_neg = (B_SIGNED != 0) && b[B_WIDTH-1];

  always_comb begin
    sc = NONE;
    if (b == '0)                sc = ZERO_EXP;
    else if (b_neg) begin
      if (a_wide == '0)         sc = UNDEF;
      else if (a_wide == 65'd1) sc = ONE;
      else if (a_wide == '1)    sc = MINUS_ONE;
      else                      sc = ZERO;
    end
  end

  always_comb begin
    case (sc)
      ZERO_EXP, ONE: special_y = Y_WIDTH'(1);
      MINUS_ONE:     special_y = b[0] ? '1 : Y_WIDTH'(1);
      default:       special_y = '0;
    endcase
  end

  vh_pow_step #(.Y_WIDTH(Y_WIDTH)) u_step (
    .acc_i      (acc_q),
    .base_i     (base_q),
    .bit_i      (exp_q[0]),
    .acc_next_o (acc_step),
    .base_next_o(base_step)
  );

`ifdef VH_POW_EARLY_EXIT_EN
  assign last_step = (cnt_q == CW'(B_WIDTH - 1)) || ((exp_q >> 1) == '0);
`else
  assign last_step = (cnt_q == CW'(B_WIDTH - 1));
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    undef_d = undef_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          undef_d = (sc == UNDEF);
          if (sc == NONE) begin
            acc_d   = Y_WIDTH'(1);
            base_d  = a_ext;
            exp_d   = b;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            acc_d   = special_y;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        acc_d  = acc_step;
        base_d = base_step;
        exp_d  = exp_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          undef_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      undef_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      undef_q <= undef_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = acc_q;
  assign y_undef   = undef_q;

endmodule
